// File: rtl/board_lock_clear_pkg.sv
// Shared board geometry, row/board types and line-clear FSM state encoding.
// Pure declarations: no latency, no flow control.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef row_t [BOARD_ROWS-1:0] board_t;

  localparam row_t FULL_ROW = 10'h3FF;

  typedef enum logic [2:0] {
    LC_IDLE     = 3'd0,
    LC_MERGE    = 3'd1,
    LC_SCAN     = 3'd2,
    LC_CHECK    = 3'd3,
    LC_SPAWN    = 3'd4,
    LC_GAMEOVER = 3'd5
  } lc_state_t;

  // Drop every row above r down by one; row 0 refills empty.
  function automatic board_t collapse_row(board_t b, logic [4:0] r);
    board_t n;
    n = b;
    for (int i = 1; i < BOARD_ROWS; i++) begin
      if (i <= int'(r)) n[i] = b[i-1];
    end
    n[0] = '0;
    return n;
  endfunction

endpackage

// File: rtl/board_lock_clear_if.sv
// Piece-landing / board-status bundle between the falling-piece block (master) and the line-clear engine (slave).
// Wires only: no latency, no flow control beyond the fell edge and Spawn pulse.
interface board_lock_clear_if;
  import tetris_pkg::*;

  logic        fell;
  logic        startGame;
  board_t      currBlocks;
  board_t      fallenBlocks;
  logic        Spawn;
  logic        lineBreak;
  logic        gameOver;
  logic [15:0] linesCleared;
  logic [9:0]  difficulty;
  logic        busy;

  modport master (
    output fell, startGame, currBlocks,
    input  fallenBlocks, Spawn, lineBreak, gameOver, linesCleared, difficulty, busy
  );

  modport slave (
    input  fell, startGame, currBlocks,
    output fallenBlocks, Spawn, lineBreak, gameOver, linesCleared, difficulty, busy
  );

endinterface

// File: rtl/board_lock_clear_line_level_counter.sv
// Cleared-line total plus level sub-counter with saturating difficulty.
// One-cycle registered update per inc; clr wins over inc, never stalls.
module line_level_counter #(
  parameter int START_LEVEL     = 0,
  parameter int MAX_LEVEL       = 1023,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] lines_cleared,
  output logic [9:0]  level
);

  logic [3:0] sub_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lines_cleared <= '0;
      sub_cnt       <= '0;
      level         <= 10'(START_LEVEL);
    end else if (inc) begin
      lines_cleared <= lines_cleared + 16'd1;
      if (sub_cnt == 4'(LINES_PER_LEVEL - 1)) begin
        sub_cnt <= '0;
        if (level < 10'(MAX_LEVEL)) level <= level + 10'd1;
      end else begin
        sub_cnt <= sub_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/board_lock_clear.sv
// Merges a landed piece into the board, clears full rows bottom-up and requests the next piece.
// Spawn 22+k edges after an accepted fell edge (k = rows cleared); fell edges outside IDLE are dropped.
module board_lock_clear
  import tetris_pkg::*;
#(
  parameter int START_LEVEL     = 0,
  parameter int MAX_LEVEL       = 1023,
  parameter int LINES_PER_LEVEL = 10
) (
  input logic               clk,
  input logic               Reset,
  board_lock_clear_if.slave bus
);

  lc_state_t  state;
  logic [4:0] row_ptr;
  logic       fell_q;
  board_t     board;
  logic       spawn_q;
  logic       line_break_q;
  logic       game_over_q;
  logic       busy_q;
  logic       clear_hit;
  logic [15:0] lines_total;
  logic [9:0]  level;

  always_comb begin
    clear_hit = 1'b0;
    if (state == LC_SCAN && board[row_ptr] == FULL_ROW) clear_hit = 1'b1;
  end

  line_level_counter #(
    .START_LEVEL     (START_LEVEL),
    .MAX_LEVEL       (MAX_LEVEL),
    .LINES_PER_LEVEL (LINES_PER_LEVEL)
  ) u_counter (
    .clk           (clk),
    .rst           (Reset),
    .clr           (bus.startGame),
    .inc           (clear_hit),
    .lines_cleared (lines_total),
    .level         (level)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state        <= LC_IDLE;
      row_ptr      <= 5'd19;
      fell_q       <= 1'b0;
      board        <= '0;
      spawn_q      <= 1'b0;
      line_break_q <= 1'b0;
      game_over_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fell_q       <= bus.fell;
      spawn_q      <= 1'b0;
      line_break_q <= 1'b0;
      if (bus.startGame) begin
        board       <= '0;
        game_over_q <= 1'b0;
        state       <= LC_SPAWN;
        busy_q      <= 1'b1;
      end else begin
        case (state)
          LC_IDLE: begin
            if (bus.fell && !fell_q) begin
              state  <= LC_MERGE;
              busy_q <= 1'b1;
            end
          end
          LC_MERGE: begin
            board <= board | bus.currBlocks;
            if ((board & bus.currBlocks) != '0) begin
              state       <= LC_GAMEOVER;
              game_over_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state   <= LC_SCAN;
              row_ptr <= 5'd19;
            end
          end
          LC_SCAN: begin
            // Pointer holds after a clear so the row shifted in is examined next.
            if (clear_hit) begin
              board        <= collapse_row(board, row_ptr);
              line_break_q <= 1'b1;
            end else if (row_ptr == 5'd0) begin
              state <= LC_CHECK;
            end else begin
              row_ptr <= row_ptr - 5'd1;
            end
          end
          LC_CHECK: begin
            if (board[0] != '0 || board[1] != '0) begin
              state       <= LC_GAMEOVER;
              game_over_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state   <= LC_SPAWN;
              spawn_q <= 1'b1;
            end
          end
          LC_SPAWN: begin
            // Entered from CHECK the pulse is already out; entered via startGame it launches now.
            state   <= LC_IDLE;
            spawn_q <= !spawn_q;
            busy_q  <= 1'b0;
          end
          LC_GAMEOVER: begin
            state <= LC_GAMEOVER;
          end
          default: begin
            state  <= LC_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fallenBlocks = board;
  assign bus.Spawn        = spawn_q;
  assign bus.lineBreak    = line_break_q;
  assign bus.gameOver     = game_over_q;
  assign bus.linesCleared = lines_total;
  assign bus.difficulty   = level;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_board_lock_clear.sv
// Self-checking bench for board_lock_clear: vector table, corner sequences, random pieces vs a row-list model.
module tb_board_lock_clear;
  import tetris_pkg::*;

  localparam int START = 2;
  localparam int MAXL  = 1023;
  localparam int LPL   = 10;

  logic clk;
  logic Reset;
  int   tests;
  int   fails;

  board_lock_clear_if bus();

  board_lock_clear #(
    .START_LEVEL     (START),
    .MAX_LEVEL       (MAXL),
    .LINES_PER_LEVEL (LPL)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    row_t p17;
    row_t p18;
    row_t p19;
    int   exp_spawn;
    int   exp_breaks;
    bit   exp_go;
    row_t exp_r18;
    row_t exp_r19;
    int   exp_lines;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic board_t mk3(row_t a17, row_t a18, row_t a19);
    board_t b;
    b = '0;
    b[17] = a17;
    b[18] = a18;
    b[19] = a19;
    return b;
  endfunction

  // Result of locking piece p onto board b, stated as "merge, then drop every full row".
  function automatic void model_lock(input board_t b, input board_t p, output board_t nb,
                                     output int k, output bit go, output int spawn_at, output int go_at);
    row_t merged[BOARD_ROWS];
    row_t kept[$];
    bit   overlap;
    overlap = 0;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      merged[r] = b[r] | p[r];
      if ((b[r] & p[r]) != '0) overlap = 1;
    end
    nb = '0;
    if (overlap) begin
      for (int r = 0; r < BOARD_ROWS; r++) nb[r] = merged[r];
      k = 0; go = 1; go_at = 1; spawn_at = -1;
      return;
    end
    for (int r = 0; r < BOARD_ROWS; r++)
      if (merged[r] != 10'h3FF) kept.push_back(merged[r]);
    k = BOARD_ROWS - kept.size();
    for (int i = 0; i < kept.size(); i++) nb[k+i] = kept[i];
    if (nb[0] != '0 || nb[1] != '0) begin
      go = 1; go_at = 22 + k; spawn_at = -1;
    end else begin
      go = 0; go_at = -1; spawn_at = 22 + k;
    end
  endfunction

  // Raises fell with the given piece; index e means "observed in the cycle after edge E_e".
  task automatic run_piece(input board_t piece, output int spawn_at, output int breaks,
                           output int go_at, output int spawns);
    bus.currBlocks = piece;
    bus.fell       = 1'b1;
    spawn_at = -1; go_at = -1; breaks = 0; spawns = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (e == 0) bus.fell = 1'b0;
      if (bus.lineBreak) breaks++;
      if (bus.Spawn) begin
        spawns++;
        if (spawn_at < 0) spawn_at = e;
      end
      if (bus.gameOver && go_at < 0) go_at = e;
    end
    bus.currBlocks = '0;
  endtask

  task automatic start_game();
    bus.startGame = 1'b1;
    @(negedge clk);
    bus.startGame = 1'b0;
    check("sg_board_zero", bus.fallenBlocks, '0);
    check("sg_gameover_clr", bus.gameOver, 0);
    check("sg_spawn_not_yet", bus.Spawn, 0);
    check("sg_lines_zero", bus.linesCleared, 0);
    @(negedge clk);
    check("sg_spawn", bus.Spawn, 1);
    check("sg_level", bus.difficulty, START);
    @(negedge clk);
    check("sg_spawn_one_cycle", bus.Spawn, 0);
  endtask

  board_t mb, p, nb;
  int     k, sp, ga, mlines, rsp, rbr, rga, rsc, spawn_cnt, exp_diff;
  bit     go;

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    bus.fell = 1'b0;
    bus.startGame = 1'b0;
    bus.currBlocks = '0;

    vecs[0] = '{10'h000, 10'h3F0, 10'h3F0, 22, 0, 1'b0, 10'h3F0, 10'h3F0, 0};
    vecs[1] = '{10'h000, 10'h00F, 10'h00F, 24, 2, 1'b0, 10'h000, 10'h000, 2};
    vecs[2] = '{10'h000, 10'h000, 10'h00F, 22, 0, 1'b0, 10'h000, 10'h00F, 2};
    vecs[3] = '{10'h000, 10'h001, 10'h3F0, 23, 1, 1'b0, 10'h000, 10'h001, 3};
    vecs[4] = '{10'h0F0, 10'h3FF, 10'h3FE, 24, 2, 1'b0, 10'h000, 10'h0F0, 5};
    vecs[5] = '{10'h000, 10'h000, 10'h110, -1, 0, 1'b1, 10'h000, 10'h1F0, 5};

    repeat (3) @(negedge clk);
    Reset = 1'b0;
    check("rst_board", bus.fallenBlocks, '0);
    check("rst_spawn", bus.Spawn, 0);
    check("rst_linebreak", bus.lineBreak, 0);
    check("rst_gameover", bus.gameOver, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_lines", bus.linesCleared, 0);
    check("rst_level", bus.difficulty, START);
    spawn_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.Spawn) spawn_cnt++;
    end
    check("rst_no_spawn", spawn_cnt, 0);

    // Vector table applied as one game.
    start_game();
    for (int i = 0; i < 6; i++) begin
      run_piece(mk3(vecs[i].p17, vecs[i].p18, vecs[i].p19), rsp, rbr, rga, rsc);
      check($sformatf("vec%0d_spawn_edge", i), rsp, vecs[i].exp_spawn);
      check($sformatf("vec%0d_linebreaks", i), rbr, vecs[i].exp_breaks);
      check($sformatf("vec%0d_gameover", i), bus.gameOver, vecs[i].exp_go);
      check($sformatf("vec%0d_row18", i), bus.fallenBlocks[18], vecs[i].exp_r18);
      check($sformatf("vec%0d_row19", i), bus.fallenBlocks[19], vecs[i].exp_r19);
      check($sformatf("vec%0d_lines", i), bus.linesCleared, vecs[i].exp_lines);
      check($sformatf("vec%0d_level", i), bus.difficulty, START);
    end
    check("overlap_go_edge", rga, 1);
    check("gameover_busy", bus.busy, 0);
    run_piece(mk3(10'h000, 10'h003, 10'h000), rsp, rbr, rga, rsc);
    check("gameover_fell_ignored_spawn", rsc, 0);
    check("gameover_fell_ignored_row18", bus.fallenBlocks[18], 10'h000);
    check("gameover_sticky", bus.gameOver, 1);

    // A clear pushes a top-row cell into row 1: game over at CHECK.
    start_game();
    p = '0;
    p[0]  = 10'h010;
    p[19] = 10'h3FF;
    run_piece(p, rsp, rbr, rga, rsc);
    check("row1_go_edge", rga, 23);
    check("row1_no_spawn", rsc, 0);
    check("row1_breaks", rbr, 1);
    check("row1_row1", bus.fallenBlocks[1], 10'h010);

    // fell held high spans two pieces: only the first lands.
    start_game();
    bus.currBlocks = mk3(10'h000, 10'h000, 10'h00F);
    bus.fell = 1'b1;
    spawn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Spawn) spawn_cnt++;
    end
    bus.currBlocks = mk3(10'h000, 10'h00F, 10'h000);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Spawn) spawn_cnt++;
    end
    bus.fell = 1'b0;
    bus.currBlocks = '0;
    @(negedge clk);
    check("held_fell_spawns", spawn_cnt, 1);
    check("held_fell_row18", bus.fallenBlocks[18], 10'h000);
    check("held_fell_row19", bus.fallenBlocks[19], 10'h00F);

    // Ten single-row clears step the level once.
    start_game();
    for (int i = 0; i < 10; i++) begin
      run_piece(mk3(10'h000, 10'h000, 10'h3FF), rsp, rbr, rga, rsc);
      if (i == 8) check("nine_clears_level", bus.difficulty, START);
    end
    check("ten_clears_spawn_edge", rsp, 23);
    check("ten_clears_lines", bus.linesCleared, 10);
    check("ten_clears_level", bus.difficulty, START + 1);

    // startGame while SCAN is mid-board.
    bus.currBlocks = mk3(10'h000, 10'h000, 10'h00F);
    bus.fell = 1'b1;
    @(negedge clk);
    bus.fell = 1'b0;
    repeat (9) @(negedge clk);
    check("scan_busy", bus.busy, 1);
    start_game();
    bus.currBlocks = '0;
    spawn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Spawn) spawn_cnt++;
    end
    check("scan_abort_no_spawn", spawn_cnt, 0);
    check("scan_abort_board", bus.fallenBlocks, '0);

    // Random pieces against the model.
    start_game();
    mb = '0;
    mlines = 0;
    for (int n = 0; n < 30; n++) begin
      p = '0;
      for (int r = 14; r < BOARD_ROWS; r++) begin
        case ($urandom_range(0, 3))
          0:       p[r] = ~mb[r];
          1:       p[r] = row_t'($urandom) & ~mb[r];
          default: p[r] = '0;
        endcase
      end
      if ($urandom_range(0, 9) == 0) p[19] = p[19] | mb[19];
      if ($urandom_range(0, 11) == 0) p[0] = row_t'($urandom_range(1, 1022));
      model_lock(mb, p, nb, k, go, sp, ga);
      run_piece(p, rsp, rbr, rga, rsc);
      mlines += k;
      exp_diff = START + mlines / LPL;
      if (exp_diff > MAXL) exp_diff = MAXL;
      check($sformatf("rnd%0d_spawn_edge", n), rsp, sp);
      check($sformatf("rnd%0d_go_edge", n), rga, ga);
      check($sformatf("rnd%0d_breaks", n), rbr, k);
      check($sformatf("rnd%0d_board", n), bus.fallenBlocks, nb);
      check($sformatf("rnd%0d_lines", n), bus.linesCleared, mlines);
      check($sformatf("rnd%0d_level", n), bus.difficulty, exp_diff);
      if (go) begin
        start_game();
        mb = '0;
        mlines = 0;
      end else begin
        mb = nb;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
